// File: rtl/aes_sbox_pkg.sv
// Shared AES S-box tables, engine FSM encoding and mask-scan helper.
// Latency: n/a (constants and a combinational function).
// Backpressure: n/a.
package aes_sbox_pkg;

    typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

    localparam int MAX_ROWS = 16;

    localparam logic [7:0] SBOX_FWD [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] SBOX_INV [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Lowest set bit at or above `from`; returns 0 when none remain, so callers
    // must test the mask for emptiness themselves.
    function automatic logic [3:0] first_set(input logic [MAX_ROWS-1:0] mask, input logic [4:0] from);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = MAX_ROWS - 1; i >= 0; i--) begin
            if (mask[i] && (i >= int'(from))) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sbox_lut.sv
// Single-byte AES S-box / inverse S-box lookup.
// Latency: 0 cycles (combinational).
// Backpressure: none.
module sbox_lut
    import aes_sbox_pkg::*;
(
    input  logic [7:0] char_dat,
    input  logic       inverse,
    output logic [7:0] sub_dat
);

    assign sub_dat = inverse ? SBOX_INV[char_dat] : SBOX_FWD[char_dat];

endmodule

// File: rtl/sbox_row_engine.sv
// Row-serial SubBytes/InvSubBytes over a masked ROWS x COLS character matrix.
// Latency: popcount(mask)+1 edges from accept to out_valid, unmasked rows cost nothing.
// Backpressure: one matrix in flight; result held in DONE until out_ready, in_ready only in IDLE.
module sbox_row_engine
    import aes_sbox_pkg::*;
#(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int DATA_W = 8
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [ROWS*COLS*DATA_W-1:0] in_matrix,
    input  logic [ROWS-1:0]             in_row_mask,
    input  logic                        in_inverse,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ROWS*COLS*DATA_W-1:0] out_matrix,
    output logic                        out_inverse
);

    localparam int ROW_W = COLS * DATA_W;
    localparam int MAT_W = ROWS * ROW_W;

    state_t                  state_q, state_nxt;
    logic [MAT_W-1:0]        buf_q;
    logic [ROWS-1:0]         mask_q, mask_clr;
    logic [3:0]              ptr_q;
    logic                    mode_q;
    logic                    accept;
    logic [ROW_W-1:0]        row_cur, row_sub;
    logic [COLS-1:0][7:0]    sub_dat;

    // Gating with resetn keeps in_ready low for the whole time reset is held.
    assign in_ready    = resetn && (state_q == IDLE);
    assign accept      = in_valid && in_ready;
    assign out_matrix  = buf_q;
    assign out_inverse = mode_q;
    assign mask_clr    = mask_q & ~(ROWS'(1) << ptr_q);

    always_comb begin
        row_cur = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (ptr_q == 4'(r)) row_cur = buf_q[r*ROW_W +: ROW_W];
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_lut
        sbox_lut u_lut (
            .char_dat (row_cur[c*DATA_W +: 8]),
            .inverse  (mode_q),
            .sub_dat  (sub_dat[c])
        );
    end

    // Only the low byte of each character is substituted; upper bits ride along.
    always_comb begin
        row_sub = row_cur;
        for (int c = 0; c < COLS; c++) begin
            row_sub[c*DATA_W +: 8] = sub_dat[c];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) state_nxt = (in_row_mask != '0) ? SUB : DONE;
            end
            SUB: begin
                if (mask_clr == '0) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            buf_q  <= '0;
            mask_q <= '0;
            ptr_q  <= '0;
            mode_q <= 1'b0;
        end else if (accept) begin
            buf_q  <= in_matrix;
            mask_q <= in_row_mask;
            ptr_q  <= first_set(MAX_ROWS'(in_row_mask), 5'd0);
            mode_q <= in_inverse;
        end else if (state_q == SUB) begin
            for (int r = 0; r < ROWS; r++) begin
                if (ptr_q == 4'(r)) buf_q[r*ROW_W +: ROW_W] <= row_sub;
            end
            mask_q <= mask_clr;
            ptr_q  <= first_set(MAX_ROWS'(mask_clr), 5'(ptr_q) + 5'd1);
        end
    end

endmodule

// File: doc/sbox_row_engine.md
Name: sbox_row_engine

Overview:
- Parametrised, clocked successor to the combinational sbox block: applies AES SubBytes (forward) or InvSubBytes (inverse) to a ROWS x COLS matrix of characters, with per-row masking.
- Processes one masked-in row per clock using a bank of COLS S-box lookups; unmasked rows bypass in zero cycles.
- Sits between the state register and ShiftRows in the encryption/decryption round datapath.
- Uses valid/ready handshakes on both sides.

Parameters:
- ROWS, 4, number of matrix rows (1..16).
- COLS, 4, characters per row, equal to the number of parallel lookups (1..16).
- DATA_W, 8, character width (>=8). Bits [7:0] are substituted; bits [DATA_W-1:8] pass through unchanged.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- resetn  in  1  asynchronous active-low reset.
- in_valid  in  1  input matrix offered.
- in_ready  out  1  engine can accept a matrix.
- in_matrix  in  ROWS*COLS*DATA_W  element (r,c) at bits [(r*COLS+c)*DATA_W +: DATA_W].
- in_row_mask  in  ROWS  bit r=1: substitute row r; bit r=0: pass row r unchanged.
- in_inverse  in  1  0 = forward S-box, 1 = inverse S-box.
- out_valid  out  1  result matrix available.
- out_ready  in  1  consumer accepts the result.
- out_matrix  out  ROWS*COLS*DATA_W  result, same layout as in_matrix.
- out_inverse  out  1  echo of the in_inverse value captured with this matrix.

Behaviour:
- Reset (resetn=0, asynchronous):
  - state = IDLE; out_valid = 0; in_ready = 0 while resetn is low.
  - out_matrix = 0; out_inverse = 0; internal buffer, mask and row pointer cleared.
  - in_ready = 1 from the first clock edge after deassertion.
- FSM states: IDLE, SUB, DONE. in_ready = (state == IDLE) only.
- IDLE:
  - On in_valid & in_ready: capture in_matrix into the buffer, and capture in_row_mask and in_inverse.
  - If the mask is non-zero: go to SUB with the row pointer at the lowest set mask bit.
  - If the mask is zero: go straight to DONE.
- SUB, each cycle:
  - Replace the low 8 bits of all COLS characters of row[ptr] with S(x) or InvS(x).
  - Clear mask bit ptr and move ptr to the next higher set bit.
  - When no set bits remain: go to DONE.
  - Input changes during SUB are ignored.
- DONE:
  - out_valid = 1; out_matrix = buffer; out_inverse = captured mode. These stay stable while out_valid & !out_ready.
  - On out_ready: go to IDLE, out_valid drops next cycle. No back-to-back accept on the same edge.
- Latency:
  - out_valid rises popcount(mask)+1 edges after the accepting edge.
  - Minimum 1 (mask = 0); maximum ROWS+1.
  - Throughput is one matrix per popcount(mask)+2 cycles with out_ready held high.
- Boundaries:
  - A mask with only bit ROWS-1 set takes 1 SUB cycle (no scanning cycles for empty rows).
  - Mask bits beyond ROWS do not exist; X on in_row_mask while in_valid=0 is ignored.
  - out_ready asserted outside DONE has no effect.
  - resetn asserted during SUB or DONE aborts the operation: the result is discarded and out_valid drops immediately (asynchronously).
- Lookup is combinational from the 256-entry tables. The only registers are the buffer, mask, pointer, mode and FSM state.

Decomposition:
- Package aes_sbox_pkg holds:
  - SBOX_FWD and SBOX_INV: 256 x 8-bit constant arrays.
  - The FSM enum: IDLE/SUB/DONE.
  - Function first_set(mask, from), returning the index of the lowest set bit at or above from.
- Sub-module sbox_lut: 8-bit in, inverse select, 8-bit out, purely combinational. It is instantiated COLS times in a generate loop on the selected row.

Test Plan:
- Reset then forward accept, ROWS=4, COLS=4, DATA_W=8, mask=4'hF, all bytes 0x00 -> out_valid 5 edges after accept; all bytes 0x63; out_inverse=0.
- Inverse mode, mask=4'h1, row0={0x63,0xED,0x7C,0x16}, rows1-3=0x53 -> row0={0x00,0x53,0x01,0xFF}; rows1-3 unchanged 0x53; latency 2.
- Mask=0, in_matrix byte values 0..15 -> out_matrix identical to input; out_valid 1 edge after accept.
- DATA_W=16, mask=4'h8, row3 chars 0xAB53 -> row3 chars 0xABED; rows0-2 unchanged; latency 2.
- Backpressure: out_ready held 0 for 10 cycles in DONE -> out_valid and out_matrix stable and in_ready=0 throughout; one out_ready pulse -> IDLE, in_ready=1 on the next edge.
- resetn pulsed low mid-SUB (mask=4'hF, after 2 SUB cycles) -> out_valid=0 and out_matrix=0 immediately; no result is emitted; the next matrix is processed correctly.
